ysyx_24070017_rf_wb_ctrl: RTL and testbench



---
 rtl/ysyx_24070017_rf_wb_ctrl_pkg.sv | 17 +
 rtl/ysyx_24070017_rf_scoreboard.sv | 63 ++++++
 rtl/ysyx_24070017_rf_wb_ctrl.sv | 108 ++++++++++
 tb/tb_ysyx_24070017_rf_wb_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070017_rf_wb_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
//   ysyx_24070017_RF_REG_NUM  : number of architectural registers
//   ysyx_24070017_WORD_LENGTH : register width in bits
//   ysyx_24070017_RF_ADDR_W   : register index width, clog2(REG_NUM)
//   wb_req_e                  : writeback requester identity (EXU / LSU)
package ysyx_24070017_rf_wb_ctrl_pkg;

  localparam int ysyx_24070017_RF_REG_NUM  = 32;
  localparam int ysyx_24070017_WORD_LENGTH = 32;
  localparam int ysyx_24070017_RF_ADDR_W   = 5;

  typedef enum logic {
    ysyx_24070017_WB_EXU = 1'b0,
    ysyx_24070017_WB_LSU = 1'b1
  } wb_req_e;

endpackage

// File: rtl/ysyx_24070017_rf_scoreboard.sv
// Per-register busy scoreboard used by the issue stage for RAW/WAW checks.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   flush                    : drop every reservation (and any same-cycle mark)
//   mark_valid, mark_rd      : reservation request from issue
//   mark_ready               : reservation accepted (target not already busy)
//   wb_fire, wb_rd           : a writeback retires this cycle to wb_rd
//   rs1_idx/rs2_idx          : source indices to look up
//   rs1_busy/rs2_busy        : registered busy state of those sources
module ysyx_24070017_rf_scoreboard
  import ysyx_24070017_rf_wb_ctrl_pkg::*;
#(
  parameter int REG_NUM = ysyx_24070017_RF_REG_NUM,
  parameter int ADDR_W  = ysyx_24070017_RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mark_valid,
  input  logic [ADDR_W-1:0] mark_rd,
  output logic              mark_ready,
  input  logic              wb_fire,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [ADDR_W-1:0] rs1_idx,
  input  logic [ADDR_W-1:0] rs2_idx,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_next;

  // busy[0] never gets set, so x0 is always ready to be marked and never busy.
  assign mark_ready = rst & ~busy[mark_rd];
  // Lookups read the registered vector only: a register retiring this cycle
  // still reports busy until the following cycle.
  assign rs1_busy   = rst & busy[rs1_idx];
  assign rs2_busy   = rst & busy[rs2_idx];

  // Clear is applied before set; a same-rd clear+set cannot actually occur
  // because a busy target holds mark_ready low.
  always_comb begin
    busy_next = busy;
    if (wb_fire) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (flush) begin
      busy_next = '0;
    end else if (mark_valid && mark_ready && (mark_rd != '0)) begin
      busy_next[mark_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/ysyx_24070017_rf_wb_ctrl.sv
// Register-file writeback controller.
// Arbitrates one RF write port between EXU and LSU with round-robin on
// conflicts, decodes the granted rd into a one-hot write enable, replicates
// the granted data across all RF slots, and hosts the busy scoreboard.
// Ports:
//   clk, rst                        : clock, synchronous active-low reset
//   exu_valid/ready, exu_rd/data    : EXU writeback channel
//   lsu_valid/ready, lsu_rd/data    : LSU writeback channel
//   mark_valid/ready, mark_rd       : destination reservation from issue
//   rs1_idx/rs2_idx, rs1/rs2_busy   : hazard lookups
//   flush                           : clear all reservations
//   rf_we, rf_wdata                 : RF write enable vector and flat data bus
//
// Handshake: a transfer completes in any cycle where valid && ready. A source
// holds valid, rd and data stable until it sees ready. ready depends only on
// the valids and the arbiter state, never the reverse.
module ysyx_24070017_rf_wb_ctrl
  import ysyx_24070017_rf_wb_ctrl_pkg::*;
#(
  parameter int REG_NUM     = ysyx_24070017_RF_REG_NUM,
  parameter int WORD_LENGTH = ysyx_24070017_WORD_LENGTH,
  parameter int ADDR_W      = ysyx_24070017_RF_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           exu_valid,
  output logic                           exu_ready,
  input  logic [ADDR_W-1:0]              exu_rd,
  input  logic [WORD_LENGTH-1:0]         exu_data,
  input  logic                           lsu_valid,
  output logic                           lsu_ready,
  input  logic [ADDR_W-1:0]              lsu_rd,
  input  logic [WORD_LENGTH-1:0]         lsu_data,
  input  logic                           mark_valid,
  output logic                           mark_ready,
  input  logic [ADDR_W-1:0]              mark_rd,
  input  logic [ADDR_W-1:0]              rs1_idx,
  input  logic [ADDR_W-1:0]              rs2_idx,
  output logic                           rs1_busy,
  output logic                           rs2_busy,
  input  logic                           flush,
  output logic [REG_NUM-1:0]             rf_we,
  output logic [REG_NUM*WORD_LENGTH-1:0] rf_wdata
);

  wb_req_e                last_winner;
  logic                   grant_exu;
  logic                   grant_lsu;
  logic                   wb_fire;
  logic [ADDR_W-1:0]      wb_rd;
  logic [WORD_LENGTH-1:0] wb_data;

  // On a conflict the side that did not win the previous conflict goes.
  // Everything is gated by rst so all outputs read 0 while in reset.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (rst) begin
      grant_exu = exu_valid && (!lsu_valid || (last_winner == ysyx_24070017_WB_LSU));
      grant_lsu = lsu_valid && (!exu_valid || (last_winner == ysyx_24070017_WB_EXU));
    end
  end

  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;
  assign wb_fire   = grant_exu | grant_lsu;
  assign wb_rd     = grant_lsu ? lsu_rd   : exu_rd;
  assign wb_data   = grant_lsu ? lsu_data : exu_data;

  // x0 writes are accepted but never reach the RF.
  always_comb begin
    rf_we = '0;
    if (wb_fire && (wb_rd != '0)) begin
      rf_we[wb_rd] = 1'b1;
    end
  end

  assign rf_wdata = wb_fire ? {REG_NUM{wb_data}} : '0;

  // Only conflict cycles move the round-robin pointer. Reset to LSU makes
  // EXU win the first conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_winner <= ysyx_24070017_WB_LSU;
    end else if (exu_valid && lsu_valid) begin
      last_winner <= grant_lsu ? ysyx_24070017_WB_LSU : ysyx_24070017_WB_EXU;
    end
  end

  ysyx_24070017_rf_scoreboard #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .mark_valid (mark_valid),
    .mark_rd    (mark_rd),
    .mark_ready (mark_ready),
    .wb_fire    (wb_fire),
    .wb_rd      (wb_rd),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

endmodule

// File: tb/tb_ysyx_24070017_rf_wb_ctrl.sv
// Bench for ysyx_24070017_rf_wb_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural model of the arbitration and
// reservation rules. A small RF array captures the DUT's write port.
module tb_ysyx_24070017_rf_wb_ctrl;

  localparam int RN = 32;
  localparam int WL = 32;
  localparam int AW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] exu_rd, lsu_rd, mark_rd, rs1_idx, rs2_idx;
  logic [WL-1:0] exu_data, lsu_data;
  logic          mark_valid, mark_ready, rs1_busy, rs2_busy, flush;
  logic [RN-1:0] rf_we;
  logic [RN*WL-1:0] rf_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_24070017_rf_wb_ctrl #(
    .REG_NUM     (RN),
    .WORD_LENGTH (WL),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exu_valid  (exu_valid),
    .exu_ready  (exu_ready),
    .exu_rd     (exu_rd),
    .exu_data   (exu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .mark_valid (mark_valid),
    .mark_ready (mark_ready),
    .mark_rd    (mark_rd),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .flush      (flush),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata)
  );

  // ---------------- reference model state ----------------
  bit            busy_m[RN];
  int            last_w;        // 0 = EXU won last conflict, 1 = LSU
  logic [WL-1:0] rf_m[RN];      // expected RF contents
  logic [WL-1:0] rf_cap[RN];    // RF contents as written by the DUT

  // expected {exu_ready, lsu_ready, mark_ready, rs1_busy, rs2_busy, rf_we}
  logic [36:0]   exp_q[$];
  logic [WL-1:0] exp_d_q[$];    // value expected in every rf_wdata slot

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  initial begin
    for (int i = 0; i < RN; i++) begin
      rf_cap[i] = '0;
      rf_m[i]   = '0;
      busy_m[i] = 1'b0;
    end
    last_w = 1;
  end

  always @(posedge clk) begin
    for (int i = 0; i < RN; i++) begin
      if (rf_we[i]) rf_cap[i] <= rf_wdata[i*WL +: WL];
    end
  end

  task automatic check_word(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs at the falling edge, derives the expected
  // outputs from the model, and advances the model across the next rising edge.
  // g returns the model's grant: -1 none, 0 EXU, 1 LSU.
  task automatic step(input logic r,
                      input logic ev, input logic [AW-1:0] erd, input logic [WL-1:0] ed,
                      input logic lv, input logic [AW-1:0] lrd, input logic [WL-1:0] ld,
                      input logic mv, input logic [AW-1:0] mrd,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic fl, output int g);
    logic [RN-1:0] we_e;
    logic [WL-1:0] gd;
    logic [AW-1:0] grd;
    logic          mr;
    @(negedge clk);
    rst = r; exu_valid = ev; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    mark_valid = mv; mark_rd = mrd; rs1_idx = r1; rs2_idx = r2; flush = fl;
    g = -1;
    if (!r) begin
      exp_q.push_back('0);
      exp_d_q.push_back('0);
      for (int i = 0; i < RN; i++) busy_m[i] = 1'b0;
      last_w = 1;
    end else begin
      if (ev && lv)  g = (last_w == 1) ? 0 : 1;
      else if (ev)   g = 0;
      else if (lv)   g = 1;
      grd  = (g == 1) ? lrd : erd;
      gd   = (g == 1) ? ld  : ed;
      we_e = '0;
      if (g >= 0 && grd != 0) we_e = RN'(1) << grd;
      mr   = (mrd == 0) || !busy_m[mrd];
      exp_q.push_back({g == 0, g == 1, mr, busy_m[r1], busy_m[r2], we_e});
      exp_d_q.push_back(g >= 0 ? gd : '0);
      if (ev && lv) last_w = g;
      if (g >= 0 && grd != 0) begin
        rf_m[grd]   = gd;
        busy_m[grd] = 1'b0;
      end
      if (fl) begin
        for (int i = 0; i < RN; i++) busy_m[i] = 1'b0;
      end else if (mv && mr && mrd != 0) begin
        busy_m[mrd] = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    int g;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 0, g);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [36:0]   ec;
    logic [WL-1:0] ed;
    bit            ok;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        ec = exp_q.pop_front();
        ed = exp_d_q.pop_front();
        checks++;
        if ({exu_ready, lsu_ready, mark_ready, rs1_busy, rs2_busy} !== ec[36:32]) begin
          errors++;
          $display("FAIL ctrl {exu_rdy,lsu_rdy,mark_rdy,rs1_busy,rs2_busy} actual=%b expected=%b @%0t",
                   {exu_ready, lsu_ready, mark_ready, rs1_busy, rs2_busy}, ec[36:32], $time);
        end
        checks++;
        if (rf_we !== ec[31:0]) begin
          errors++;
          $display("FAIL rf_we actual=%h expected=%h @%0t", rf_we, ec[31:0], $time);
        end
        ok = 1'b1;
        for (int i = 0; i < RN; i++) if (rf_wdata[i*WL +: WL] !== ed) ok = 1'b0;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL rf_wdata slot0 actual=%h expected=%h (all slots) @%0t",
                   rf_wdata[WL-1:0], ed, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int            g;
    logic          e_pend, l_pend, r, mv, fl;
    logic [AW-1:0] e_rd, l_rd, mrd;
    logic [WL-1:0] e_d, l_d;

    rst = 1'b0; exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    mark_valid = 1'b0; mark_rd = '0; rs1_idx = '0; rs2_idx = '0; flush = 1'b0;

    // reset, with live requests that must be ignored
    step(0, 1, 5, 32'h1111_1111, 1, 6, 32'h2222_2222, 1, 7, 7, 6, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // single EXU write
    step(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0, 0, g);
    idle(5, 0);
    check_word("x5_after_write", rf_cap[5], 32'hDEAD_BEEF);

    // three-cycle conflict, each side re-presenting after its grant
    step(1, 1, 3, 32'hE000_0001, 1, 4, 32'hA000_0001, 0, 0, 3, 4, 0, g);
    step(1, 1, 3, 32'hE000_0002, 1, 4, 32'hA000_0001, 0, 0, 3, 4, 0, g);
    step(1, 1, 3, 32'hE000_0002, 1, 4, 32'hA000_0002, 0, 0, 3, 4, 0, g);

    // LSU write to x0
    step(1, 0, 0, 0, 1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, g);
    idle(0, 0);
    check_word("x0_stays_zero", rf_cap[0], 32'h0);

    // reserve x7, retry (WAW stall), retire via LSU, reserve again
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, g);
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, g);
    step(1, 0, 0, 0, 1, 7, 32'h0777_0777, 1, 7, 7, 0, 0, g);
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, g);
    step(1, 1, 7, 32'h7070_7070, 0, 0, 0, 0, 0, 7, 7, 0, g);
    idle(7, 0);

    // reserve x9, x10, then flush together with a mark and an EXU write
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 10, 0, g);
    step(1, 0, 0, 0, 0, 0, 0, 1, 10, 9, 10, 0, g);
    step(1, 1, 12, 32'h0C0C_0C0C, 0, 0, 0, 1, 11, 9, 10, 1, g);
    idle(9, 10);
    idle(11, 12);

    // reset with a reservation outstanding and EXU mid-request
    step(1, 0, 0, 0, 0, 0, 0, 1, 6, 6, 0, 0, g);
    step(0, 1, 6, 32'h0606_0606, 0, 0, 0, 0, 0, 6, 6, 0, g);
    step(0, 1, 6, 32'h0606_0606, 0, 0, 0, 0, 0, 6, 6, 0, g);
    for (int i = 0; i < RN; i += 2) idle(AW'(i), AW'(i + 1));

    // randomized traffic
    e_pend = 1'b0; l_pend = 1'b0;
    e_rd = '0; l_rd = '0; e_d = '0; l_d = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!e_pend && $urandom_range(0, 99) < 55) begin
        e_pend = 1'b1;
        e_rd   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, RN - 1));
        e_d    = $urandom;
      end
      if (!l_pend && $urandom_range(0, 99) < 55) begin
        l_pend = 1'b1;
        l_rd   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, RN - 1));
        l_d    = $urandom;
      end
      mv  = ($urandom_range(0, 99) < 45);
      mrd = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, RN - 1));
      fl  = ($urandom_range(0, 99) < 3);
      r   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      step(r, e_pend, e_rd, e_d, l_pend, l_rd, l_d, mv, mrd,
           AW'($urandom_range(0, RN - 1)), AW'($urandom_range(0, 7)), fl, g);
      if (!r) begin
        e_pend = 1'b0;
        l_pend = 1'b0;
      end else if (g == 0) begin
        e_pend = 1'b0;
      end else if (g == 1) begin
        l_pend = 1'b0;
      end
    end
    idle(0, 0);
    idle(0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 entries left", exp_q.size());
    end
    for (int i = 0; i < RN; i++) check_word($sformatf("rf_x%0d_final", i), rf_cap[i], rf_m[i]);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // overall time bound
  initial begin
    #500000;
    if (!done) begin
      errors++;
      $display("FAIL timeout actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule
